// File: rtl/score_display_ctrl.sv
// ---------------------------------------------------------------------------
// score_display_ctrl
//   Pong score keeper and 4-digit 7-segment display scanner.
//   Counts single-cycle point pulses into two saturating BCD scores,
//   detects the match winner (PLAY -> OVER), and time-multiplexes the four
//   score digits through one shared BCD-to-segment decoder. In OVER the
//   winner's digits blink.
//
// Ports
//   in_CLK         system clock, rising edge
//   in_RST_N       asynchronous active-low reset
//   in_P1_POINT    1-cycle pulse, P1 scored
//   in_P2_POINT    1-cycle pulse, P2 scored
//   in_CLEAR       synchronous new-match clear (wins over point pulses)
//   out_SEG        segments {g,f,e,d,c,b,a}, active-low
//   out_DIGIT_SEL  digit anodes, active-low, bit3 = leftmost
//   out_WINNER     00 none, 01 P1, 10 P2, 11 tie
//   out_GAME_OVER  high while in OVER
// ---------------------------------------------------------------------------
module score_display_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250,
    parameter int WIN_SCORE = 11
) (
    input  logic       in_CLK,
    input  logic       in_RST_N,
    input  logic       in_P1_POINT,
    input  logic       in_P2_POINT,
    input  logic       in_CLEAR,
    output logic [6:0] out_SEG,
    output logic [3:0] out_DIGIT_SEL,
    output logic [1:0] out_WINNER,
    output logic       out_GAME_OVER
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic {ST_PLAY, ST_OVER} state_e;

    state_e           state_q, state_d;
    logic [7:0]       p1_q, p1_d;          // {tens, units}
    logic [7:0]       p2_q, p2_d;
    logic [1:0]       winner_q, winner_d;
    logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;

    // BCD +1 with carry into tens, saturating at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic       tick;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] p1_nxt, p2_nxt;
    logic       hit1, hit2;

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        seg_d       = seg_q;
        sel_d       = sel_q;
        idx_d       = idx_q;

        // ---- scan timing: counter is never disturbed by in_CLEAR ----
        tick       = (scan_cnt_q == SCW'(SCAN_DIV - 1));
        scan_cnt_d = tick ? '0 : scan_cnt_q + SCW'(1);

        // ---- shared decode path: pick the digit for the current slot ----
        case (idx_q)
            2'd0:    nib = p2_q[3:0];
            2'd1:    nib = p2_q[7:4];
            2'd2:    nib = p1_q[3:0];
            default: nib = p1_q[7:4];
        endcase
        // slots 2/3 belong to P1 (winner bit 0), slots 0/1 to P2 (bit 1)
        blank = blink_q && (idx_q[1] ? winner_q[0] : winner_q[1]);

        // anode and segments load on the same edge so they always match
        if (tick) begin
            seg_d = blank ? 7'b1111111 : bcd_to_seg(nib);
            sel_d = ~(4'b0001 << idx_q);
            idx_d = idx_q + 2'd1;
        end

        // ---- blink phase: only advances in OVER, on scan ticks ----
        if (in_CLEAR || state_q == ST_PLAY) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (tick) begin
            if (blink_cnt_q == BLW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLW'(1);
            end
        end

        // ---- scores and match FSM ----
        p1_nxt = in_P1_POINT ? bcd_inc(p1_q) : p1_q;
        p2_nxt = in_P2_POINT ? bcd_inc(p2_q) : p2_q;
        hit1   = in_P1_POINT && (p1_nxt == WIN_BCD);
        hit2   = in_P2_POINT && (p2_nxt == WIN_BCD);

        if (in_CLEAR) begin
            p1_d     = '0;
            p2_d     = '0;
            state_d  = ST_PLAY;
            winner_d = 2'b00;
        end else if (state_q == ST_PLAY) begin
            p1_d = p1_nxt;
            p2_d = p2_nxt;
            if (hit1 || hit2) begin
                state_d  = ST_OVER;
                winner_d = {hit2, hit1};
            end
        end
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_q     <= ST_PLAY;
            p1_q        <= '0;
            p2_q        <= '0;
            winner_q    <= 2'b00;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            seg_q       <= 7'b1111111;
            sel_q       <= 4'b1111;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
        end
    end

    assign out_SEG       = seg_q;
    assign out_DIGIT_SEL = sel_q;
    assign out_WINNER    = winner_q;
    assign out_GAME_OVER = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_display_ctrl
//   Self-checking bench for score_display_ctrl. A second instance with
//   WIN_SCORE=99 covers carry and saturation.
// ---------------------------------------------------------------------------
module tb_score_display_ctrl;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int W  = 11;

    logic       clk, rst_n;
    logic       p1, p2, clr;
    logic [6:0] seg;
    logic [3:0] sel;
    logic [1:0] win;
    logic       over;

    logic       b_p1, b_p2, b_clr;
    logic [6:0] b_seg;
    logic [3:0] b_sel;
    logic [1:0] b_win;
    logic       b_over;

    int total = 0;
    int bad   = 0;

    score_display_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD), .WIN_SCORE(W)) dut (
        .in_CLK(clk), .in_RST_N(rst_n), .in_P1_POINT(p1), .in_P2_POINT(p2),
        .in_CLEAR(clr), .out_SEG(seg), .out_DIGIT_SEL(sel),
        .out_WINNER(win), .out_GAME_OVER(over)
    );

    score_display_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(1000), .WIN_SCORE(99)) dut99 (
        .in_CLK(clk), .in_RST_N(rst_n), .in_P1_POINT(b_p1), .in_P2_POINT(b_p2),
        .in_CLEAR(b_clr), .out_SEG(b_seg), .out_DIGIT_SEL(b_sel),
        .out_WINNER(b_win), .out_GAME_OVER(b_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (decimal scores) ----------------
    int         m_s1, m_s2, m_bcnt, m_scnt, m_idx;
    bit         m_over, m_phase;
    logic [1:0] m_win;
    logic [6:0] m_seg;
    logic [3:0] m_sel;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_bcnt = 0; m_scnt = 0; m_idx = 0;
        m_over = 0; m_phase = 0; m_win = 2'b00;
        m_seg = 7'b1111111; m_sel = 4'b1111;
    endtask

    task automatic model_step(input bit a, input bit b, input bit c);
        int  d, n1, n2;
        bit  tick, blank, h1, h2;
        tick = (m_scnt == SD - 1);
        if (tick) begin
            case (m_idx)
                0: d = m_s2 % 10;
                1: d = m_s2 / 10;
                2: d = m_s1 % 10;
                default: d = m_s1 / 10;
            endcase
            blank = m_phase && ((m_idx >= 2) ? m_win[0] : m_win[1]);
            m_seg = blank ? 7'b1111111 : seg_of(d);
            m_sel = 4'b1111 ^ (4'b0001 << m_idx);
            m_idx = (m_idx + 1) % 4;
        end
        m_scnt = tick ? 0 : m_scnt + 1;
        if (c || !m_over) begin
            m_phase = 0; m_bcnt = 0;
        end else if (tick) begin
            if (m_bcnt == BD - 1) begin m_phase = !m_phase; m_bcnt = 0; end
            else m_bcnt = m_bcnt + 1;
        end
        if (c) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 2'b00;
        end else if (!m_over) begin
            n1 = a ? ((m_s1 < 99) ? m_s1 + 1 : 99) : m_s1;
            n2 = b ? ((m_s2 < 99) ? m_s2 + 1 : 99) : m_s2;
            h1 = a && (n1 == W);
            h2 = b && (n2 == W);
            m_s1 = n1; m_s2 = n2;
            if (h1 || h2) begin m_over = 1; m_win = {h2, h1}; end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("seg",  {25'd0, seg},  {25'd0, m_seg});
        chk("sel",  {28'd0, sel},  {28'd0, m_sel});
        chk("win",  {30'd0, win},  {30'd0, m_win});
        chk("over", {31'd0, over}, {31'd0, m_over});
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input bit a, input bit b, input bit c);
        p1 = a; p2 = b; clr = c;
        @(posedge clk);
        model_step(a, b, c);
        @(negedge clk);
        check_all();
        p1 = 0; p2 = 0; clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_seg",  {25'd0, seg},  32'h7F);
        chk("rst_sel",  {28'd0, sel},  32'hF);
        chk("rst_win",  {30'd0, win},  32'h0);
        chk("rst_over", {31'd0, over}, 32'h0);
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- table for static score display ----------------
    typedef struct {
        int         n1;
        int         n2;
        logic [6:0] exp_seg [4];   // by digit index 0..3
    } vec_t;

    vec_t vecs [5];

    int         nblank1, nblank2, nshown1;
    logic [6:0] cap [4];
    logic [6:0] b_units, b_tens;

    initial begin
        rst_n = 0; p1 = 0; p2 = 0; clr = 0;
        b_p1 = 0; b_p2 = 0; b_clr = 0;

        vecs[0] = '{3,  7,  '{7'b1111000, 7'b1000000, 7'b0110000, 7'b1000000}};
        vecs[1] = '{5,  10, '{7'b1000000, 7'b1111001, 7'b0010010, 7'b1000000}};
        vecs[2] = '{8,  2,  '{7'b0100100, 7'b1000000, 7'b0000000, 7'b1000000}};
        vecs[3] = '{10, 9,  '{7'b0011000, 7'b1000000, 7'b1000000, 7'b1111001}};
        vecs[4] = '{4,  6,  '{7'b0000010, 7'b1000000, 7'b0011001, 7'b1000000}};

        do_reset();

        // scan order after reset, zeros shown
        for (int k = 0; k < 4; k++) begin
            repeat (SD) cycle(0, 0, 0);
            chk("scan_sel", {28'd0, sel}, {28'd0, 4'b1111 ^ (4'b0001 << k)});
            chk("scan_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        end

        // carry and saturation on the WIN_SCORE=99 instance
        repeat (10) begin b_p1 = 1; cycle(0, 0, 0); b_p1 = 0; end
        for (int i = 0; i < 17; i++) begin
            cycle(0, 0, 0);
            if (b_sel == 4'b1011) b_units = b_seg;
            if (b_sel == 4'b0111) b_tens  = b_seg;
        end
        chk("carry_units", {25'd0, b_units}, {25'd0, 7'b1000000});
        chk("carry_tens",  {25'd0, b_tens},  {25'd0, 7'b1111001});
        repeat (99) begin b_p1 = 1; cycle(0, 0, 0); b_p1 = 0; end
        for (int i = 0; i < 17; i++) begin
            cycle(0, 0, 0);
            if (b_sel == 4'b1011) b_units = b_seg;
            if (b_sel == 4'b0111) b_tens  = b_seg;
        end
        chk("sat_units", {25'd0, b_units}, {25'd0, 7'b0011000});
        chk("sat_tens",  {25'd0, b_tens},  {25'd0, 7'b0011000});
        chk("sat_over",  {31'd0, b_over},  32'd1);
        chk("sat_win",   {30'd0, b_win},   32'd1);

        // table-driven static score display
        for (int v = 0; v < 5; v++) begin
            cycle(0, 0, 1);
            for (int i = 0; i < vecs[v].n1; i++) cycle(1, 0, 0);
            for (int i = 0; i < vecs[v].n2; i++) cycle(0, 1, 0);
            for (int i = 0; i < 17; i++) begin
                cycle(0, 0, 0);
                for (int s = 0; s < 4; s++)
                    if (sel == (4'b1111 ^ (4'b0001 << s))) cap[s] = seg;
            end
            for (int s = 0; s < 4; s++)
                chk($sformatf("vec%0d_slot%0d", v, s), {25'd0, cap[s]}, {25'd0, vecs[v].exp_seg[s]});
        end

        // P1 wins, P2 frozen, P1 digits blink
        cycle(0, 0, 1);
        repeat (10) cycle(1, 0, 0);
        chk("p1_pre_over", {31'd0, over}, 32'd0);
        cycle(1, 0, 0);
        chk("p1_over", {31'd0, over}, 32'd1);
        chk("p1_win",  {30'd0, win},  32'd1);
        repeat (3) cycle(0, 1, 0);
        nblank1 = 0; nblank2 = 0; nshown1 = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(0, 1, 0);
            if (sel == 4'b1011 || sel == 4'b0111) begin
                if (seg == 7'b1111111) nblank1++; else nshown1++;
            end
            if ((sel == 4'b1110 || sel == 4'b1101) && seg == 7'b1111111) nblank2++;
        end
        chk("p1_blank_seen", {31'd0, nblank1 > 0}, 32'd1);
        chk("p1_shown_seen", {31'd0, nshown1 > 0}, 32'd1);
        chk("p2_no_blank",   nblank2, 32'd0);

        // simultaneous win -> tie, all digits blink
        cycle(0, 0, 1);
        repeat (10) cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("tie_win",  {30'd0, win},  32'd3);
        chk("tie_over", {31'd0, over}, 32'd1);
        nblank1 = 0; nblank2 = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 0);
            if ((sel == 4'b1011 || sel == 4'b0111) && seg == 7'b1111111) nblank1++;
            if ((sel == 4'b1110 || sel == 4'b1101) && seg == 7'b1111111) nblank2++;
        end
        chk("tie_blank_p1", {31'd0, nblank1 > 0}, 32'd1);
        chk("tie_blank_p2", {31'd0, nblank2 > 0}, 32'd1);

        // clear beats a point pulse in OVER
        cycle(1, 0, 1);
        chk("clr_win",  {30'd0, win},  32'd0);
        chk("clr_over", {31'd0, over}, 32'd0);
        repeat (6) cycle(0, 0, 0);

        // reset mid-scan: outputs drop immediately, restart from index 0
        @(negedge clk); #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_sel", {28'd0, sel}, 32'hF);
        @(negedge clk);
        chk("midrst_hold_sel", {28'd0, sel}, 32'hF);
        rst_n = 1;
        repeat (SD - 1) cycle(0, 0, 0);
        chk("restart_idle", {28'd0, sel}, 32'hF);
        cycle(0, 0, 0);
        chk("restart_idx0", {28'd0, sel}, 32'hE);

        // randomized play against the model
        for (int i = 0; i < 4000; i++)
            cycle(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 80) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
